// File: rtl/alu_writeback.sv
// Commit stage behind the ALU: pipe register, accumulator/Z/C update, regfile write port, skip squash.
// Optional ALU_WB_SHADOW_EN adds interrupt shadow save/restore of accum and flags.
module alu_writeback #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_in_valid,
  input  logic                      i_stall,
  input  logic [DATA_WIDTH-1:0]     i_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_dest_addr,
  input  logic                      i_accum_write,
  input  logic                      i_reg_write,
  input  logic                      i_z_write,
  input  logic                      i_zout,
  input  logic                      i_c_write,
  input  logic                      i_cout,
  input  logic                      i_skip,
  input  logic                      i_retint,
  input  logic                      i_int_enter,
  output logic [DATA_WIDTH-1:0]     o_accum,
  output logic                      o_z_flag,
  output logic                      o_c_flag,
  output logic                      o_rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_wr_addr,
  output logic [DATA_WIDTH-1:0]     o_rf_wr_data,
  output logic                      o_squashed,
  output logic                      o_retint_done
);

  typedef enum logic {NORMAL, SKIP_PENDING} state_t;

  state_t                    r_state;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [REG_ADDR_WIDTH-1:0] r_dest;
  logic                      r_accum_write, r_reg_write;
  logic                      r_z_write, r_zout, r_c_write, r_cout;
  logic                      r_skip, r_retint;
  logic [DATA_WIDTH-1:0]     r_accum;
  logic                      r_z, r_c;

  logic w_commit, w_squash, w_live;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_dest        <= '0;
      r_accum_write <= 1'b0;
      r_reg_write   <= 1'b0;
      r_z_write     <= 1'b0;
      r_zout        <= 1'b0;
      r_c_write     <= 1'b0;
      r_cout        <= 1'b0;
      r_skip        <= 1'b0;
      r_retint      <= 1'b0;
    end else if (!i_stall) begin
      r_valid       <= i_in_valid;
      r_result      <= i_result;
      r_dest        <= i_dest_addr;
      r_accum_write <= i_accum_write;
      r_reg_write   <= i_reg_write;
      r_z_write     <= i_z_write;
      r_zout        <= i_zout;
      r_c_write     <= i_c_write;
      r_cout        <= i_cout;
      r_skip        <= i_skip;
      r_retint      <= i_retint;
    end
  end

  assign w_commit = r_valid & ~i_stall;
  assign w_squash = w_commit & (r_state == SKIP_PENDING);
  assign w_live   = w_commit & ~w_squash;

  // int_enter always wins; a squashed slot only clears the pending skip, never re-arms it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= NORMAL;
    end else if (i_int_enter) begin
      r_state <= NORMAL;
    end else if (w_commit) begin
      if (w_squash)    r_state <= NORMAL;
      else if (r_skip) r_state <= SKIP_PENDING;
    end
  end

`ifdef ALU_WB_SHADOW_EN
  logic [DATA_WIDTH-1:0] r_sh_accum;
  logic                  r_sh_z, r_sh_c;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sh_accum <= '0;
      r_sh_z     <= 1'b0;
      r_sh_c     <= 1'b0;
    end else if (i_int_enter) begin
      r_sh_accum <= r_accum;
      r_sh_z     <= r_z;
      r_sh_c     <= r_c;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_accum <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else if (w_live) begin
`ifdef ALU_WB_SHADOW_EN
      // restore overrides the retint's own writes; a same-cycle save suppresses it
      if (r_retint && !i_int_enter) begin
        r_accum <= r_sh_accum;
        r_z     <= r_sh_z;
        r_c     <= r_sh_c;
      end else
`endif
      begin
        if (r_accum_write) r_accum <= r_result;
        if (r_z_write)     r_z     <= r_zout;
        if (r_c_write)     r_c     <= r_cout;
      end
    end
  end

  assign o_accum       = r_accum;
  assign o_z_flag      = r_z;
  assign o_c_flag      = r_c;
  assign o_rf_wr_en    = w_live & r_reg_write;
  assign o_rf_wr_addr  = r_dest;
  assign o_rf_wr_data  = r_result;
  assign o_squashed    = w_squash;
  assign o_retint_done = w_live & r_retint;

endmodule
